// File: rtl/cmpsr_arbiter.sv
// cmpsr_arbiter: round-robin arbiter of three requesters onto the TX composer start interface.
// Optional START timeout abort is enabled by defining CMPSR_ARB_TIMEOUT_EN.
module cmpsr_arbiter #(
  parameter int START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [95:0] addr_in,
  input  logic [95:0] data_in,
  input  logic        cmpsr_busy,
  output logic        start_request_to_cmpsr,
  output logic [31:0] raw_address_to_cmpsr,
  output logic [31:0] data_out_to_cmpsr,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic        arb_busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT_FIN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, win, nxt_ptr;
  logic [2:0] grant_q, grant_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic abort;

  function automatic logic [1:0] mod3(input logic [2:0] v);
    mod3 = v >= 3'd3 ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win = rr_ptr_q;
    for (int k = 2; k >= 0; k--)
      win = req[mod3({1'b0, rr_ptr_q} + 3'(k))] ? mod3({1'b0, rr_ptr_q} + 3'(k)) : win;
  end

  assign nxt_ptr = mod3({1'b0, owner_q} + 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: if (|req && !cmpsr_busy) begin
        owner_d = win;
        grant_d = 3'b001 << win;
        addr_d  = addr_in[32*win +: 32];
        data_d  = data_in[32*win +: 32];
        state_d = START;
      end
      START: if (cmpsr_busy) state_d = WAIT_FIN;
        else if (abort) begin
          grant_d  = '0;
          rr_ptr_d = nxt_ptr;
          state_d  = IDLE;
        end
      WAIT_FIN: if (!cmpsr_busy) state_d = DONE;
      default: if (lock[owner_q] && req[owner_q]) begin
        addr_d  = addr_in[32*owner_q +: 32];
        data_d  = data_in[32*owner_q +: 32];
        state_d = START;
      end else begin
        grant_d  = '0;
        rr_ptr_d = nxt_ptr;
        state_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    start_request_to_cmpsr = state_q == START;
    done                   = state_q == DONE ? grant_q : '0;
    arb_busy               = state_q != IDLE;
  end

  assign grant                = grant_q;
  assign raw_address_to_cmpsr = addr_q;
  assign data_out_to_cmpsr    = data_q;

`ifdef CMPSR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(START_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  assign abort = state_q == START && !cmpsr_busy && cnt_q == CW'(START_TIMEOUT - 1);
  always_comb begin
    cnt_d = state_q == START ? cnt_q + 1'b1 : '0;
    err_d = abort ? grant_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign abort = 1'b0;
  assign err   = '0;
`endif
endmodule
